// File: rtl/start_frame_encoder.sv
// Start-pattern generator for the SDCKA/SDCKB line pair: emits N SDCKB pulses
// while SDCKA is held low, with every phase lasting PHASE_CYCLES clocks.
module start_frame_encoder #(
  parameter int unsigned PHASE_CYCLES = 8
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       start_valid,
  input  logic [1:0] start_type,
  output logic       start_ready,
  output logic       sdcka_out,
  output logic       sdckb_out,
  output logic       sdck_oe,
  output logic       done
);

  localparam int unsigned PHASE_W = 8;
  localparam int unsigned PULSE_W = 4;
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(PHASE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEAD   = 3'd1,
    A_LOW  = 3'd2,
    B_LOW  = 3'd3,
    B_HIGH = 3'd4,
    A_HIGH = 3'd5,
    DONE   = 3'd6
  } state_e;

  state_e               state_q, state_d;
  logic [PHASE_W-1:0]   phase_q, phase_d;
  logic [PULSE_W-1:0]   pulse_q, pulse_d;
  logic [PULSE_W-1:0]   target_q, target_d;
  logic                 sdcka_q, sdcka_d;
  logic                 sdckb_q, sdckb_d;
  logic                 oe_q, oe_d;
  logic                 ready_q, ready_d;
  logic                 done_q, done_d;
  logic                 phase_end;

  // Pulse count per start type: frame, with_crc, occupancy, reset.
  function automatic logic [PULSE_W-1:0] pulses_for(input logic [1:0] t);
    case (t)
      2'b00:   pulses_for = PULSE_W'(4);
      2'b01:   pulses_for = PULSE_W'(6);
      2'b10:   pulses_for = PULSE_W'(8);
      default: pulses_for = PULSE_W'(14);
    endcase
  endfunction

  // Next-state, counters and next output values; outputs are decoded from
  // state_d so the line levels change on the same edge as the state.
  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    sdcka_d   = 1'b1;
    sdckb_d   = 1'b1;
    oe_d      = 1'b0;
    ready_d   = 1'b0;
    done_d    = 1'b0;
    phase_end = (phase_q == PHASE_LAST);

    case (state_q)
      IDLE: begin
        if (start_valid && ready_q) begin
          state_d  = LEAD;
          target_d = pulses_for(start_type);
        end
      end
      LEAD:    if (phase_end) state_d = A_LOW;
      A_LOW:   if (phase_end) state_d = B_LOW;
      B_LOW:   if (phase_end) state_d = B_HIGH;
      B_HIGH:  if (phase_end) state_d = (pulse_q < target_q) ? B_LOW : A_HIGH;
      A_HIGH:  if (phase_end) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if ((state_q == IDLE) || (state_d != state_q)) begin
      phase_d = '0;
    end else begin
      phase_d = phase_q + PHASE_W'(1);
    end

    if (state_d == IDLE) begin
      pulse_d = '0;
    end else if ((state_d == B_LOW) && (state_q != B_LOW)) begin
      pulse_d = pulse_q + PULSE_W'(1);
    end else begin
      pulse_d = pulse_q;
    end

    case (state_d)
      IDLE:   ready_d = 1'b1;
      LEAD:   oe_d    = 1'b1;
      A_LOW: begin
        sdcka_d = 1'b0;
        oe_d    = 1'b1;
      end
      B_LOW: begin
        sdcka_d = 1'b0;
        sdckb_d = 1'b0;
        oe_d    = 1'b1;
      end
      B_HIGH: begin
        sdcka_d = 1'b0;
        oe_d    = 1'b1;
      end
      A_HIGH:  oe_d   = 1'b1;
      DONE:    done_d = 1'b1;
      default: ready_d = 1'b0;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      pulse_q  <= '0;
      target_q <= '0;
      sdcka_q  <= 1'b1;
      sdckb_q  <= 1'b1;
      oe_q     <= 1'b0;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      pulse_q  <= pulse_d;
      target_q <= target_d;
      sdcka_q  <= sdcka_d;
      sdckb_q  <= sdckb_d;
      oe_q     <= oe_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
    end
  end

  assign start_ready = ready_q;
  assign sdcka_out   = sdcka_q;
  assign sdckb_out   = sdckb_q;
  assign sdck_oe     = oe_q;
  assign done        = done_q;

endmodule

// File: tb/tb_start_frame_encoder.sv
// Directed bench for start_frame_encoder: a PHASE_CYCLES=2 instance for single
// patterns, busy-ignore and abort, and a PHASE_CYCLES=1 instance for back-to-back.
module tb_start_frame_encoder;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic       v2 = 1'b0, v1 = 1'b0;
  logic [1:0] t2 = 2'b00, t1 = 2'b00;
  logic       rdy2, a2, b2, oe2, dn2;
  logic       rdy1, a1, b1, oe1, dn1;

  int checks = 0;
  int errors = 0;

  start_frame_encoder #(.PHASE_CYCLES(2)) u_p2 (
    .aclk(aclk), .aresetn(aresetn), .start_valid(v2), .start_type(t2),
    .start_ready(rdy2), .sdcka_out(a2), .sdckb_out(b2), .sdck_oe(oe2), .done(dn2)
  );

  start_frame_encoder #(.PHASE_CYCLES(1)) u_p1 (
    .aclk(aclk), .aresetn(aresetn), .start_valid(v1), .start_type(t1),
    .start_ready(rdy1), .sdcka_out(a1), .sdckb_out(b1), .sdck_oe(oe1), .done(dn1)
  );

  // Line monitors: count SDCKB falls while SDCKA low, oe cycles, done pulses.
  int   cyc = 0;
  int   neg2 = 0, oec2 = 0, done2 = 0, brise2 = 0, arise2 = 0;
  logic pb2 = 1'b1, pa2 = 1'b1;
  int   neg1 = 0, oec1 = 0, done1 = 0, idle1 = 0;
  logic pb1 = 1'b1;
  int   cneg1 [3];
  int   coe1  [3];
  int   cidle1[3];

  always @(negedge aclk) begin
    cyc <= cyc + 1;
    if (!a2 && pb2 && !b2) neg2 <= neg2 + 1;
    if (oe2) oec2 <= oec2 + 1;
    if (dn2) done2 <= done2 + 1;
    if (b2 && !pb2) brise2 <= cyc;
    if (a2 && !pa2) arise2 <= cyc;
    pb2 <= b2;
    pa2 <= a2;
  end

  always @(negedge aclk) begin
    if (!a1 && pb1 && !b1) neg1 <= neg1 + 1;
    if (oe1) oec1 <= oec1 + 1;
    if (rdy1 && !oe1) idle1 <= idle1 + 1;
    if (dn1) begin
      done1 <= done1 + 1;
      if (done1 < 3) begin
        cneg1[done1]  <= neg1;
        coe1[done1]   <= oec1;
        cidle1[done1] <= idle1;
      end
    end
    pb1 <= b1;
  end

  task automatic tick();
    @(negedge aclk);
    #1;
  endtask

  task automatic start_p2(input logic [1:0] ty);
    int n = 0;
    while (rdy2 !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    t2 = ty;
    v2 = 1'b1;
    @(posedge aclk);
    #1;
    v2 = 1'b0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) tick();
    checks++; if (rdy2 !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", rdy2); end
    checks++; if (a2 !== 1'b1) begin errors++; $display("FAIL reset_a got=%b exp=1", a2); end
    checks++; if (b2 !== 1'b1) begin errors++; $display("FAIL reset_b got=%b exp=1", b2); end
    checks++; if (oe2 !== 1'b0) begin errors++; $display("FAIL reset_oe got=%b exp=0", oe2); end
    checks++; if (dn2 !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", dn2); end
    aresetn = 1'b1;
    tick();
    checks++; if (rdy2 !== 1'b1) begin errors++; $display("FAIL release_ready got=%b exp=1", rdy2); end
    checks++; if (oe2 !== 1'b0) begin errors++; $display("FAIL release_oe got=%b exp=0", oe2); end
  endtask

  task automatic test_frame();
    int bn = neg2, bo = oec2, bd = done2;
    int n = 0;
    start_p2(2'b00);
    checks++; if (oe2 !== 1'b1 || a2 !== 1'b1 || b2 !== 1'b1) begin
      errors++; $display("FAIL frame_lead got oe=%b a=%b b=%b exp 1/1/1", oe2, a2, b2);
    end
    while ((done2 - bd) < 1 && n < 200) begin tick(); n++; end
    repeat (4) tick();
    checks++; if (done2 - bd != 1) begin errors++; $display("FAIL frame_done got=%0d exp=1", done2 - bd); end
    checks++; if (oec2 - bo != 22) begin errors++; $display("FAIL frame_oe got=%0d exp=22", oec2 - bo); end
    checks++; if (neg2 - bn != 4) begin errors++; $display("FAIL frame_pulses got=%0d exp=4", neg2 - bn); end
    checks++; if (arise2 - brise2 != 2) begin errors++; $display("FAIL frame_a_after_b got=%0d exp=2", arise2 - brise2); end
    checks++; if (rdy2 !== 1'b1 || oe2 !== 1'b0) begin
      errors++; $display("FAIL frame_idle got rdy=%b oe=%b exp 1/0", rdy2, oe2);
    end
  endtask

  task automatic test_each_type();
    logic [1:0] tys  [3] = '{2'b01, 2'b10, 2'b11};
    int         pul  [3] = '{6, 8, 14};
    int         oes  [3] = '{30, 38, 62};
    for (int k = 0; k < 3; k++) begin
      int bn = neg2, bo = oec2, bd = done2;
      int n = 0;
      start_p2(tys[k]);
      while ((done2 - bd) < 1 && n < 300) begin tick(); n++; end
      repeat (3) tick();
      checks++; if (neg2 - bn != pul[k]) begin errors++; $display("FAIL type%0d_pulses got=%0d exp=%0d", k + 1, neg2 - bn, pul[k]); end
      checks++; if (oec2 - bo != oes[k]) begin errors++; $display("FAIL type%0d_oe got=%0d exp=%0d", k + 1, oec2 - bo, oes[k]); end
      checks++; if (done2 - bd != 1) begin errors++; $display("FAIL type%0d_done got=%0d exp=1", k + 1, done2 - bd); end
    end
  endtask

  task automatic test_ignore_busy();
    int bn = neg2, bo = oec2, bd = done2;
    int n = 0;
    start_p2(2'b00);
    for (int i = 0; i < 12; i++) begin
      v2 = i[0];
      t2 = 2'(i);
      tick();
    end
    v2 = 1'b0;
    t2 = 2'b00;
    while ((done2 - bd) < 1 && n < 200) begin tick(); n++; end
    repeat (6) tick();
    checks++; if (neg2 - bn != 4) begin errors++; $display("FAIL busy_pulses got=%0d exp=4", neg2 - bn); end
    checks++; if (oec2 - bo != 22) begin errors++; $display("FAIL busy_oe got=%0d exp=22", oec2 - bo); end
    checks++; if (done2 - bd != 1) begin errors++; $display("FAIL busy_done got=%0d exp=1", done2 - bd); end
  endtask

  task automatic test_abort();
    int bn = neg2, bd = done2;
    int n = 0, bo;
    start_p2(2'b00);
    while ((neg2 - bn) < 3 && n < 100) begin tick(); n++; end
    checks++; if (b2 !== 1'b0 || a2 !== 1'b0) begin
      errors++; $display("FAIL abort_in_b_low got a=%b b=%b exp 0/0", a2, b2);
    end
    aresetn = 1'b0;
    tick();
    checks++; if (a2 !== 1'b1 || b2 !== 1'b1 || oe2 !== 1'b0) begin
      errors++; $display("FAIL abort_lines got a=%b b=%b oe=%b exp 1/1/0", a2, b2, oe2);
    end
    aresetn = 1'b1;
    tick();
    checks++; if (rdy2 !== 1'b1) begin errors++; $display("FAIL abort_ready got=%b exp=1", rdy2); end
    bo = oec2;
    repeat (40) tick();
    checks++; if (done2 != bd) begin errors++; $display("FAIL abort_done got=%0d exp=%0d", done2, bd); end
    checks++; if (oec2 != bo) begin errors++; $display("FAIL abort_oe_after got=%0d exp=%0d", oec2, bo); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] tys [3] = '{2'b01, 2'b10, 2'b11};
    int         pul [3] = '{6, 8, 14};
    int         oes [3] = '{15, 19, 31};
    int bn = neg1, bo = oec1;
    int n = 0;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (rdy1 !== 1'b1 && n < 100) begin tick(); n++; end
      t1 = tys[k];
      v1 = 1'b1;
      @(posedge aclk);
      #1;
    end
    v1 = 1'b0;
    n = 0;
    while (done1 < 3 && n < 200) begin tick(); n++; end
    repeat (3) tick();
    checks++; if (done1 != 3) begin errors++; $display("FAIL b2b_done got=%0d exp=3", done1); end
    for (int k = 0; k < 3; k++) begin
      int dn  = cneg1[k] - ((k == 0) ? bn : cneg1[k - 1]);
      int dof = coe1[k]  - ((k == 0) ? bo : coe1[k - 1]);
      checks++; if (dn != pul[k]) begin errors++; $display("FAIL b2b%0d_pulses got=%0d exp=%0d", k, dn, pul[k]); end
      checks++; if (dof != oes[k]) begin errors++; $display("FAIL b2b%0d_oe got=%0d exp=%0d", k, dof, oes[k]); end
    end
    checks++; if (cidle1[1] - cidle1[0] != 1) begin errors++; $display("FAIL b2b_gap1 got=%0d exp=1", cidle1[1] - cidle1[0]); end
    checks++; if (cidle1[2] - cidle1[1] != 1) begin errors++; $display("FAIL b2b_gap2 got=%0d exp=1", cidle1[2] - cidle1[1]); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_each_type();
    test_ignore_busy();
    test_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/start_frame_encoder.md
START_FRAME_ENCODER -- requirements
Module: start_frame_encoder

Interface
REQ-001 SHALL have parameter PHASE_CYCLES, default 8: aclk cycles per bus phase; legal range 1..256.
REQ-002 SHALL have port aclk, input, 1: clock; all state changes on rising edge.
REQ-003 SHALL have port aresetn, input, 1: reset, synchronous, active-low.
REQ-004 SHALL have port start_valid, input, 1: request to emit one start pattern.
REQ-005 SHALL have port start_type, input, 2: 00 frame (4 pulses), 01 with_crc (6), 10 occupancy (8), 11 reset (14).
REQ-006 SHALL have port start_ready, output, 1: high only in IDLE; request accepted when start_valid and start_ready are both high at a rising edge.
REQ-007 SHALL have port sdcka_out, output, 1: SDCKA drive value.
REQ-008 SHALL have port sdckb_out, output, 1: SDCKB drive value.
REQ-009 SHALL have port sdck_oe, output, 1: line output enable; high while a pattern is emitted.
REQ-010 SHALL have port done, output, 1: single-cycle pulse after pattern completes.

Function
REQ-011 All outputs SHALL be registered; no combinational input-to-output path except none.
REQ-012 States SHALL be IDLE, LEAD, A_LOW, B_LOW, B_HIGH, A_HIGH, DONE.
REQ-013 IDLE: sdcka_out=1, sdckb_out=1, sdck_oe=0, start_ready=1; on accept, sample start_type into pulse target N and go to LEAD.
REQ-014 LEAD: A=1, B=1, oe=1 for PHASE_CYCLES cycles, then A_LOW.
REQ-015 A_LOW: A=0, B=1 for PHASE_CYCLES cycles, then B_LOW.
REQ-016 B_LOW: A=0, B=0 for PHASE_CYCLES cycles, then B_HIGH; pulse counter increments on entry to B_LOW.
REQ-017 B_HIGH: A=0, B=1 for PHASE_CYCLES cycles; then B_LOW if pulse count < N, else A_HIGH.
REQ-018 A_HIGH: A=1, B=1, oe=1 for PHASE_CYCLES cycles, then DONE.
REQ-019 DONE: done=1 for exactly one cycle, oe=0, start_ready=0, A=1, B=1; then IDLE.
REQ-020 Exactly N SDCKB falling edges SHALL occur while SDCKA is low, N in {4,6,8,14}.
REQ-021 Output edges SHALL appear on the cycle following the state transition; busy span from accept edge to done pulse = PHASE_CYCLES*(3+2N) cycles, done in the cycle after.
REQ-022 Phase counter SHALL be 8 bits, counting 0..PHASE_CYCLES-1, reloading to 0 on every state change; pulse counter 4 bits, cleared in IDLE.
REQ-023 start_valid while start_ready=0 SHALL be ignored (no queueing); start_type changes after accept SHALL have no effect.
REQ-024 start_valid held high through DONE SHALL be accepted on the first IDLE cycle, giving at least one IDLE cycle (A=1, B=1, oe=0) between patterns.
REQ-025 Unused/illegal state encodings SHALL return to IDLE on the next edge.

Reset
REQ-026 While aresetn=0 at a rising edge: state=IDLE, counters=0, sdcka_out=1, sdckb_out=1, sdck_oe=0, done=0, start_ready=0.
REQ-027 Reset asserted mid-pattern SHALL abort immediately; no done pulse; start_ready=1 on first cycle after reset release.

Verification
REQ-028 PHASE_CYCLES=2, type 00 -> oe high 22 cycles, 4 SDCKB negedges while SDCKA low, SDCKA rises 2 cycles after last SDCKB rise, one done pulse.
REQ-029 PHASE_CYCLES=1, types 01,10,11 back-to-back with start_valid held -> 6/8/14 negedges, oe spans 15/19/31 cycles, one idle cycle between patterns, 3 done pulses.
REQ-030 Start_valid pulsed and start_type toggled during busy (type 00 in progress) -> ignored; exactly 4 pulses, single done.
REQ-031 aresetn low for 1 cycle during 3rd B_LOW phase -> next cycle A=1, B=1, oe=0, done never asserts, start_ready=1 after release.
REQ-032 Loopback into existing start frame decoder, PHASE_CYCLES=4, each type -> decoder flags start_frame / start_with_crc / start_occupancy / start_reset respectively, start_frame_error never set.
